// File: rtl/dpwm_pkg.sv
// Shared types and helpers for the hybrid DPWM: dead-time FSM encoding, bit reversal, default sizing.
package dpwm_pkg;

  localparam int CNT_W_DEF    = 6;
  localparam int DITHER_W_DEF = 3;
  localparam int DT_W_DEF     = 4;
  localparam int PERIOD       = 2**CNT_W_DEF;
  localparam int DUTY_W       = CNT_W_DEF + DITHER_W_DEF;
  localparam int BITREV_MAX   = 16;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_HI  = 2'd1,
    ST_LO  = 2'd2,
    ST_DT  = 2'd3
  } dt_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v, input int w);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX; i++) begin
      if (i < w) r = {r[BITREV_MAX-2:0], v[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/dpwm_deadtime_gen.sv
// Dead-time generator: turns the raw PWM level into non-overlapping high/low-side gate drives.
//   state | meaning
//   OFF   | disabled, both gates low
//   HI    | high-side gate on
//   LO    | low-side gate on
//   DT    | both low, dt_cnt holds remaining dead cycles including the current one
module dpwm_deadtime_gen
  import dpwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_shadow,
  input  logic            en,
  output logic            duty_high,
  output logic            duty_low
);

  dt_state_t       state;
  logic            tgt;
  logic [DT_W-1:0] dt_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      tgt       <= 1'b0;
      dt_cnt    <= '0;
      duty_high <= 1'b0;
      duty_low  <= 1'b0;
    end else if (!en) begin
      state     <= ST_OFF;
      duty_high <= 1'b0;
      duty_low  <= 1'b0;
    end else if (state == ST_OFF || (state == ST_HI && !raw) ||
                 (state == ST_LO && raw) || (state == ST_DT && raw != tgt)) begin
      // Any new raw level (or start-up) restarts the full dead time; dt=0 switches directly.
      tgt <= raw;
      if (dt_shadow == '0) begin
        state     <= raw ? ST_HI : ST_LO;
        duty_high <= raw;
        duty_low  <= !raw;
      end else begin
        state     <= ST_DT;
        dt_cnt    <= dt_shadow;
        duty_high <= 1'b0;
        duty_low  <= 1'b0;
      end
    end else if (state == ST_DT) begin
      if (dt_cnt <= DT_W'(1)) begin
        state     <= tgt ? ST_HI : ST_LO;
        duty_high <= tgt;
        duty_low  <= !tgt;
      end else begin
        dt_cnt <= dt_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpwm_hybrid_dt.sv
// Hybrid DPWM top: coarse period counter, per-period bit-reversed dither, shadowed duty/dead-time.
// Optional fault latch and fault port are built when DPWM_FAULT_EN is defined.
module dpwm_hybrid_dt
  import dpwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DITHER_W = DITHER_W_DEF,
  parameter int DT_W     = DT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CNT_W+DITHER_W-1:0] duty_in,
  input  logic [DT_W-1:0]           dt_in,
`ifdef DPWM_FAULT_EN
  input  logic                      fault,
`endif
  output logic                      duty_high,
  output logic                      duty_low,
  output logic                      period_start
);

  localparam int DW = CNT_W + DITHER_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   EFF_MAX = (CNT_W+1)'(2**CNT_W);

  logic [CNT_W-1:0]    cnt;
  logic [DITHER_W-1:0] frame_idx;
  logic [DITHER_W-1:0] frame_rev;
  logic [DW-1:0]       duty_sh;
  logic [DW-1:0]       duty_cur;
  logic [DT_W-1:0]     dt_sh;
  logic [DT_W-1:0]     dt_cur;
  logic                en_q;
  logic                en_rise;
  logic                wrap;
  logic                inc;
  logic [CNT_W:0]      eff_sum;
  logic [CNT_W:0]      eff;
  logic                raw;
  logic                run;

  assign en_rise = en && !en_q;
  assign wrap    = en && (cnt == CNT_MAX);

  // The en-rise cycle already runs period 0, so it uses the command ports directly.
  assign duty_cur = en_rise ? duty_in : duty_sh;
  assign dt_cur   = en_rise ? dt_in   : dt_sh;

  assign frame_rev = DITHER_W'(bitrev(BITREV_MAX'(frame_idx), DITHER_W));
  assign inc       = duty_cur[DITHER_W-1:0] > frame_rev;
  assign eff_sum   = {1'b0, duty_cur[DW-1:DITHER_W]} + (CNT_W+1)'(inc);
  assign eff       = (eff_sum > EFF_MAX) ? EFF_MAX : eff_sum;
  assign raw       = {1'b0, cnt} < eff;

  assign period_start = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      frame_idx <= '0;
      duty_sh   <= '0;
      dt_sh     <= '0;
      en_q      <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      frame_idx <= '0;
      en_q      <= 1'b0;
    end else begin
      en_q <= 1'b1;
      cnt  <= cnt + 1'b1;
      if (wrap) frame_idx <= frame_idx + 1'b1;
      if (wrap || en_rise) begin
        duty_sh <= duty_in;
        dt_sh   <= dt_in;
      end
    end
  end

`ifdef DPWM_FAULT_EN
  logic fault_lat;

  // Latched fault only clears on a period wrap, so restart is period-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        fault_lat <= 1'b0;
    else if (fault)  fault_lat <= 1'b1;
    else if (wrap)   fault_lat <= 1'b0;
  end

  assign run = en && !fault && !fault_lat;
`else
  assign run = en;
`endif

  dpwm_deadtime_gen #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .dt_shadow (dt_cur),
    .en        (run),
    .duty_high (duty_high),
    .duty_low  (duty_low)
  );

endmodule

// File: tb/tb_dpwm_hybrid_dt.sv
// Self-checking bench for dpwm_hybrid_dt: cycle model from duty/dither arithmetic and a dead-time window rule.
module tb_dpwm_hybrid_dt;

  localparam int PER = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [8:0] duty_in = '0;
  logic [3:0] dt_in = '0;
`ifdef DPWM_FAULT_EN
  logic       fault = 1'b0;
  int         m_lat = 0;
`endif
  logic       duty_high, duty_low, period_start;

  int checks = 0;
  int failures = 0;
  int hi_acc = 0, lo_acc = 0, ps_acc = 0;

  int m_cnt = 0, m_frame = 0, m_duty = 0, m_dt = 0, m_en_prev = 0;
  int hist[$];

  always #5 clk = ~clk;

  dpwm_hybrid_dt #(.CNT_W(6), .DITHER_W(3), .DT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_in      (duty_in),
    .dt_in        (dt_in),
`ifdef DPWM_FAULT_EN
    .fault        (fault),
`endif
    .duty_high    (duty_high),
    .duty_low     (duty_low),
    .period_start (period_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rev3(input int f);
    return (f % 2) * 4 + ((f / 2) % 2) * 2 + (f / 4) % 2;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_frame = 0; m_duty = 0; m_dt = 0; m_en_prev = 0;
    hist.delete();
`ifdef DPWM_FAULT_EN
    m_lat = 0;
`endif
  endtask

  // One clock cycle: sample mid-cycle, compare to the model, advance the model, return after the edge.
  task automatic cycle();
    int d, duty, eff, raw, n;
    bit rise, act, all1, all0, ehi, elo;
    @(negedge clk);
    rise = en && !m_en_prev;
    act  = en;
`ifdef DPWM_FAULT_EN
    act = en && !fault && (m_lat == 0);
`endif
    d = rise ? int'(dt_in) : m_dt;
    n = hist.size();
    ehi = 0; elo = 0;
    if (n >= d + 1) begin
      all1 = 1; all0 = 1;
      for (int k = n - 1 - d; k < n; k++) begin
        if (hist[k] != 1) all1 = 0;
        if (hist[k] != 0) all0 = 0;
      end
      ehi = all1; elo = all0;
    end
    chk("duty_high", duty_high, ehi);
    chk("duty_low", duty_low, elo);
    chk("period_start", period_start, (en && m_cnt == 0) ? 1 : 0);
    chk("both_high", duty_high & duty_low, 0);
    if (duty_high === 1'b1) hi_acc++;
    if (duty_low === 1'b1) lo_acc++;
    if (period_start === 1'b1) ps_acc++;

    duty = rise ? int'(duty_in) : m_duty;
    eff  = duty / 8 + (((duty % 8) > rev3(m_frame)) ? 1 : 0);
    if (eff > PER) eff = PER;
    raw = act ? ((m_cnt < eff) ? 1 : 0) : -1;
    hist.push_back(raw);
    if (hist.size() > 20) void'(hist.pop_front());

`ifdef DPWM_FAULT_EN
    if (fault) m_lat = 1;
    else if (m_lat != 0 && en && m_cnt == PER - 1) m_lat = 0;
`endif
    if (en) begin
      if (rise || m_cnt == PER - 1) begin
        m_duty = int'(duty_in);
        m_dt   = int'(dt_in);
      end
      if (m_cnt == PER - 1) m_frame = (m_frame + 1) % 8;
      m_cnt = (m_cnt + 1) % PER;
    end else begin
      m_cnt = 0;
      m_frame = 0;
    end
    m_en_prev = en;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clr_acc();
    hi_acc = 0; lo_acc = 0; ps_acc = 0;
  endtask

  // Restart the PWM with new settings so each phase starts from cnt=0, frame 0.
  task automatic restart(input int duty, input int dt);
    en = 1'b0;
    run(2);
    duty_in = 9'(duty);
    dt_in   = 4'(dt);
    en = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_high", duty_high, 0);
    chk("rst_low", duty_low, 0);
    chk("rst_ps", period_start, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    run(3);

    // 50% duty, no dead time
    restart(256, 0);
    run(PER);
    clr_acc();
    run(2 * PER);
    chk("t1_high", hi_acc, 64);
    chk("t1_low", lo_acc, 64);
    chk("t1_ps", ps_acc, 2);

    // fine=4 dither over one frame
    restart(260, 0);
    run(8 * PER);
    clr_acc();
    run(8 * PER);
    chk("t2_high", hi_acc, 260);

    // dead time 3
    restart(256, 3);
    run(PER);
    clr_acc();
    run(PER);
    chk("t3_high", hi_acc, 29);
    chk("t3_low", lo_acc, 29);

    // duty change mid-period takes effect at the next period
    restart(256, 0);
    run(PER);
    clr_acc();
    run(20);
    duty_in = 9'd128;
    run(PER - 20);
    chk("t4_cur_high", hi_acc, 32);
    clr_acc();
    run(PER);
    chk("t4_next_high", hi_acc, 16);

    // extremes and pulses shorter than the dead time
    restart(511, 2);
    run(PER);
    clr_acc();
    run(8 * PER);
    chk("t5_full_low", lo_acc, 0);
    restart(0, 2);
    run(PER);
    clr_acc();
    run(8 * PER);
    chk("t5_zero_high", hi_acc, 0);
    restart(64, 15);
    clr_acc();
    run(4 * PER);
    chk("t5_short_high", hi_acc, 0);

    // randomized settings, cycle-checked against the model
    for (int p = 0; p < 6; p++) begin
      restart(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)));
      run(int'($urandom_range(2, 9)) * PER + int'($urandom_range(0, PER - 1)));
    end

    // en drop mid-period, then re-enable
    restart(256, 1);
    run(PER + 37);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(2 * PER);

    // async reset in the middle of a high pulse
    restart(256, 0);
    run(PER + 10);
    chk("pre_rst_high", duty_high, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_high", duty_high, 0);
    chk("async_rst_low", duty_low, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clr_acc();
    run(2 * PER);
    chk("post_rst_ps", ps_acc, 2);

`ifdef DPWM_FAULT_EN
    restart(256, 3);
    run(PER + 5);
    fault = 1'b1;
    run(1);
    fault = 1'b0;
    run(3 * PER);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
